// File: rtl/draw_scheduler.sv
// Sequences init and per-frame draw commands into the draw core over an en/done handshake.
// Frames are paced by a refresh timer; only changed mode/channel slots are redrawn.
module draw_scheduler #(
   parameter int unsigned NUM_CH      = 2,
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned CH_CMD_BASE = 8,
   parameter int unsigned REFRESH_DIV = 1000000,
   parameter int unsigned TIMEOUT     = 65535
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     en,
   input  logic [1:0]               i_mode,
   input  logic [NUM_CH*DATA_W-1:0] i_ch_data,
   input  logic [NUM_CH-1:0]        i_ch_valid,
   input  logic                     i_force_refresh,
   output logic [3:0]               o_cmd,
   output logic [31:0]              o_data,
   output logic                     o_draw_en,
   input  logic                     i_draw_done,
   output logic                     o_init_done,
   output logic                     o_frame_done,
   output logic                     o_busy,
   output logic                     o_timeout_err,
   input  logic                     i_err_clr,
   output logic [15:0]              o_frame_cnt
);

   localparam int unsigned NUM_SLOTS = 4 + NUM_CH;
   localparam int unsigned RW        = $clog2(REFRESH_DIV);
   localparam int unsigned TW        = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      RST_GAP,
      INIT,
      WAIT,
      SNAP,
      ISSUE,
      DONE
   } state_t;

   state_t            state;
   logic [RW-1:0]     refCnt;
   logic              tick;
   logic [TW-1:0]     wdCnt;
   logic              wdExpire;
   logic              errSet;
   logic [1:0]        initIdx;
   logic [3:0]        initCmd;
   logic [3:0]        slot;
   logic [3:0]        slotCmd;
   logic [31:0]       slotData;
   logic              slotDirty;
   logic              pending;
   logic              forceAll;
   logic              frameAll;
   logic [1:0]        frameMode;
   logic [1:0]        lastMode;
   logic              modeValid;
   logic [NUM_CH-1:0] chValid;
   logic [DATA_W-1:0] shadow  [NUM_CH];
   logic [DATA_W-1:0] frameCh [NUM_CH];
   logic [DATA_W-1:0] lastCh  [NUM_CH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         refCnt <= '0;
      end else if (tick) begin
         refCnt <= '0;
      end else begin
         refCnt <= refCnt + RW'(1);
      end
   end

   assign tick     = (refCnt == RW'(REFRESH_DIV - 1));
   assign wdExpire = (wdCnt == TW'(TIMEOUT - 1));
   assign errSet   = en && o_draw_en && !i_draw_done && wdExpire;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned c = 0; c < NUM_CH; c++) shadow[c] <= '0;
      end else begin
         for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (i_ch_valid[c]) shadow[c] <= i_ch_data[c*DATA_W +: DATA_W];
         end
      end
   end

   always_comb begin
      initCmd = 4'd4;
      if (initIdx == 2'd0) initCmd = 4'd0;
      else if (initIdx == 2'd1) initCmd = 4'd1;
   end

   // Slot table: three fixed always-drawn slots, then mode, then one slot per channel.
   always_comb begin
      slotCmd   = '0;
      slotData  = '0;
      slotDirty = 1'b0;
      case (slot)
         4'd0: begin slotCmd = 4'd2; slotDirty = 1'b1; end
         4'd1: begin slotCmd = 4'd3; slotDirty = 1'b1; end
         4'd2: begin slotCmd = 4'd6; slotDirty = 1'b1; end
         4'd3: begin
            slotCmd   = 4'd7;
            slotData  = {30'd0, frameMode};
            slotDirty = frameAll || !modeValid || (frameMode != lastMode);
         end
         default: begin
            for (int unsigned c = 0; c < NUM_CH; c++) begin
               if (slot == 4'(4 + c)) begin
                  slotCmd   = 4'(CH_CMD_BASE + c);
                  slotData  = 32'(frameCh[c]);
                  slotDirty = frameAll || !chValid[c] || (frameCh[c] != lastCh[c]);
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= RST_GAP;
         o_cmd         <= '0;
         o_data        <= '0;
         o_draw_en     <= 1'b0;
         o_init_done   <= 1'b0;
         o_frame_done  <= 1'b0;
         o_busy        <= 1'b0;
         o_timeout_err <= 1'b0;
         o_frame_cnt   <= '0;
         wdCnt         <= '0;
         initIdx       <= '0;
         slot          <= '0;
         pending       <= 1'b1;
         forceAll      <= 1'b0;
         frameAll      <= 1'b0;
         frameMode     <= '0;
         lastMode      <= '0;
         modeValid     <= 1'b0;
         chValid       <= '0;
         for (int unsigned c = 0; c < NUM_CH; c++) begin
            frameCh[c] <= '0;
            lastCh[c]  <= '0;
         end
      end else begin
         // Requests are captured even while en is low so that no tick is lost.
         if (tick || i_force_refresh) pending <= 1'b1;
         else if (en && state == SNAP) pending <= 1'b0;

         if (i_force_refresh) forceAll <= 1'b1;
         else if (en && state == SNAP) forceAll <= 1'b0;

         if (errSet) o_timeout_err <= 1'b1;
         else if (i_err_clr) o_timeout_err <= 1'b0;

         if (en) begin
            case (state)
               RST_GAP: begin
                  o_busy <= 1'b1;
                  state  <= INIT;
               end
               INIT: begin
                  if (o_draw_en) begin
                     if (i_draw_done || wdExpire) begin
                        o_draw_en <= 1'b0;
                        initIdx   <= initIdx + 2'd1;
                     end else begin
                        wdCnt <= wdCnt + TW'(1);
                     end
                  end else if (initIdx == 2'd3) begin
                     o_init_done <= 1'b1;
                     o_busy      <= 1'b0;
                     state       <= WAIT;
                  end else begin
                     o_cmd     <= initCmd;
                     o_data    <= '0;
                     o_draw_en <= 1'b1;
                     wdCnt     <= '0;
                  end
               end
               WAIT: begin
                  if (pending || tick || i_force_refresh) state <= SNAP;
               end
               SNAP: begin
                  frameMode <= i_mode;
                  frameCh   <= shadow;
                  frameAll  <= forceAll;
                  // Slot 0 is always drawn, so it is requested straight away.
                  slot      <= '0;
                  o_cmd     <= 4'd2;
                  o_data    <= '0;
                  o_draw_en <= 1'b1;
                  wdCnt     <= '0;
                  o_busy    <= 1'b1;
                  state     <= ISSUE;
               end
               ISSUE: begin
                  if (o_draw_en) begin
                     if (i_draw_done) begin
                        o_draw_en <= 1'b0;
                        slot      <= slot + 4'd1;
                        if (slot == 4'd3) begin
                           lastMode  <= frameMode;
                           modeValid <= 1'b1;
                        end
                        for (int unsigned c = 0; c < NUM_CH; c++) begin
                           if (slot == 4'(4 + c)) begin
                              lastCh[c]  <= frameCh[c];
                              chValid[c] <= 1'b1;
                           end
                        end
                     end else if (wdExpire) begin
                        o_draw_en <= 1'b0;
                        slot      <= slot + 4'd1;
                     end else begin
                        wdCnt <= wdCnt + TW'(1);
                     end
                  end else if (slot == 4'(NUM_SLOTS)) begin
                     o_busy       <= 1'b0;
                     o_frame_done <= 1'b1;
                     o_frame_cnt  <= o_frame_cnt + 16'd1;
                     state        <= DONE;
                  end else if (slotDirty) begin
                     o_cmd     <= slotCmd;
                     o_data    <= slotData;
                     o_draw_en <= 1'b1;
                     wdCnt     <= '0;
                  end else begin
                     slot <= slot + 4'd1;
                  end
               end
               DONE: begin
                  o_frame_done <= 1'b0;
                  state        <= WAIT;
               end
               default: state <= RST_GAP;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_draw_scheduler.sv
// Directed bench for draw_scheduler: a frame-level model predicts every issued command,
// and a core responder answers 3 cycles after each request or never (watchdog test).
module tb_draw_scheduler;

   localparam int unsigned NUM_CH  = 2;
   localparam int unsigned TIMEOUT = 16;

   logic        clk = 1'b0;
   logic        rst_n, en, forceRefresh, drawDone, errClr;
   logic [1:0]  mode;
   logic [63:0] chData;
   logic [1:0]  chValidIn;
   logic [3:0]  cmd;
   logic [31:0] data;
   logic        drawEn, initDone, frameDone, busy, timeoutErr;
   logic [15:0] frameCnt;

   draw_scheduler #(
      .NUM_CH(NUM_CH),
      .DATA_W(32),
      .CH_CMD_BASE(8),
      .REFRESH_DIV(200),
      .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .en(en),
      .i_mode(mode),
      .i_ch_data(chData),
      .i_ch_valid(chValidIn),
      .i_force_refresh(forceRefresh),
      .o_cmd(cmd),
      .o_data(data),
      .o_draw_en(drawEn),
      .i_draw_done(drawDone),
      .o_init_done(initDone),
      .o_frame_done(frameDone),
      .o_busy(busy),
      .o_timeout_err(timeoutErr),
      .i_err_clr(errClr),
      .o_frame_cnt(frameCnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  cmd;
      logic [31:0] data;
      int          slot;
   } cmd_t;

   cmd_t        expQ[$];
   cmd_t        cur;
   logic [3:0]  logCmd[$];
   logic [31:0] logData[$];

   int vecs = 0;
   int errs = 0;

   // Model state: values the next snapshot will see, and the last successfully drawn values.
   logic [1:0]  snapMode;
   logic [31:0] snapCh   [NUM_CH];
   logic [1:0]  lastMode;
   logic [31:0] lastCh   [NUM_CH];
   bit          modeSeen;
   bit          chSeen   [NUM_CH];
   bit          forceNext;
   bit          coreNever;
   int          framesSeen;
   int          framesBuilt;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vecs++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic pushExp(input logic [3:0] c, input logic [31:0] d, input int s);
      cmd_t e;
      e = '{c, d, s};
      expQ.push_back(e);
   endtask

   task automatic buildFrame();
      pushExp(4'd2, 32'd0, 0);
      pushExp(4'd3, 32'd0, 1);
      pushExp(4'd6, 32'd0, 2);
      if (forceNext || !modeSeen || snapMode != lastMode) pushExp(4'd7, {30'd0, snapMode}, 3);
      for (int c = 0; c < NUM_CH; c++) begin
         if (forceNext || !chSeen[c] || snapCh[c] != lastCh[c]) pushExp(4'(8 + c), snapCh[c], 4 + c);
      end
      forceNext = 1'b0;
      framesBuilt++;
   endtask

   // Compare process and core responder, sampling on the falling edge.
   initial begin
      bit prevDraw = 1'b0;
      bit holdBad  = 1'b0;
      bit doneSent = 1'b0;
      int act      = 0;
      drawDone = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            expQ.delete();
            pushExp(4'd0, 32'd0, -1);
            pushExp(4'd1, 32'd0, -1);
            pushExp(4'd4, 32'd0, -1);
            modeSeen   = 1'b0;
            lastMode   = '0;
            for (int c = 0; c < NUM_CH; c++) begin
               chSeen[c] = 1'b0;
               lastCh[c] = '0;
               snapCh[c] = '0;
            end
            forceNext  = 1'b0;
            framesSeen = 0;
            prevDraw   = 1'b0;
            drawDone   = 1'b0;
            act        = 0;
            continue;
         end
         if (drawEn && !prevDraw) begin
            if (expQ.size() == 0) buildFrame();
            cur = expQ.pop_front();
            check("cmdData", {cmd, data}, {cur.cmd, cur.data});
            check("busyInCmd", busy, 1'b1);
            check("initDone", initDone, cur.slot >= 0);
            logCmd.push_back(cmd);
            logData.push_back(data);
            act      = 0;
            doneSent = 1'b0;
            holdBad  = 1'b0;
         end else if (drawEn && ({cmd, data} !== {cur.cmd, cur.data})) begin
            holdBad = 1'b1;
         end
         if (!drawEn && prevDraw) begin
            check("holdStable", holdBad, 1'b0);
            if (doneSent) begin
               check("doneLen", act, 3);
               if (cur.slot == 3) begin
                  lastMode = cur.data[1:0];
                  modeSeen = 1'b1;
               end else if (cur.slot >= 4) begin
                  lastCh[cur.slot - 4] = cur.data;
                  chSeen[cur.slot - 4] = 1'b1;
               end
            end else begin
               check("watchdogLen", act, TIMEOUT);
               check("errSet", timeoutErr, 1'b1);
            end
         end
         drawDone = 1'b0;
         if (drawEn) begin
            if (!en) begin
               drawDone = 1'b1;
            end else begin
               act++;
               if (!coreNever && act == 3) begin
                  drawDone = 1'b1;
                  doneSent = 1'b1;
               end
            end
         end
         if (frameDone) begin
            framesSeen++;
            check("frameCnt", frameCnt, framesSeen);
            check("frameLen", expQ.size(), 0);
            check("busyAtDone", busy, 1'b0);
         end
         prevDraw = drawEn;
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic waitFrames(input int n, input int budget);
      int k = 0;
      while (framesSeen < n && k < budget) begin
         step();
         k++;
      end
      check("frameWait", framesSeen >= n, 1'b1);
   endtask

   task automatic waitDrawEn(input int budget);
      int k = 0;
      while (!drawEn && k < budget) begin
         step();
         k++;
      end
      check("drawEnWait", drawEn, 1'b1);
   endtask

   task automatic clearLog();
      logCmd.delete();
      logData.delete();
   endtask

   initial begin
      int fullSeq [9] = '{0, 1, 4, 2, 3, 6, 7, 8, 9};
      int fixSeq  [3] = '{2, 3, 6};
      int fb;
      int k;
      rst_n = 1'b0; en = 1'b1; forceRefresh = 1'b0; errClr = 1'b0;
      mode = 2'd0; chData = '0; chValidIn = '0;
      snapMode = 2'd0; coreNever = 1'b0; framesBuilt = 0;
      repeat (3) step();
      check("rstDrawEn", drawEn, 1'b0);
      check("rstInitDone", initDone, 1'b0);
      check("rstCnt", frameCnt, 16'd0);
      check("rstOther", {frameDone, busy, timeoutErr, cmd, data}, '0);
      clearLog();
      rst_n = 1'b1;

      // First frame after init: every slot drawn.
      waitFrames(1, 300);
      check("seq1Len", logCmd.size(), 9);
      for (int i = 0; i < 9; i++) check("seq1", logCmd[i], fullSeq[i]);
      check("initDoneHi", initDone, 1'b1);
      check("cnt1", frameCnt, 16'd1);

      // No data change: only fixed slots.
      clearLog();
      waitFrames(2, 400);
      check("seq2Len", logCmd.size(), 3);
      for (int i = 0; i < 3; i++) check("seq2", logCmd[i], fixSeq[i]);

      // ch0 update adds its slot.
      clearLog();
      chData[31:0] = 32'h1234; chValidIn = 2'b01; snapCh[0] = 32'h1234;
      step();
      chValidIn = 2'b00;
      waitFrames(3, 400);
      check("seq3Len", logCmd.size(), 4);
      check("seq3Cmd", logCmd[3], 4'd8);
      check("seq3Data", logData[3], 32'h0000_1234);

      // Core hangs: every command times out, mode slot stays dirty.
      clearLog();
      mode = 2'd1; snapMode = 2'd1; coreNever = 1'b1;
      waitFrames(4, 400);
      check("seq4Len", logCmd.size(), 4);
      check("errSticky", timeoutErr, 1'b1);
      coreNever = 1'b0;
      step();
      errClr = 1'b1;
      step();
      errClr = 1'b0;
      check("errCleared", timeoutErr, 1'b0);

      // Timed-out mode slot is retried.
      clearLog();
      waitFrames(5, 400);
      check("seq5Len", logCmd.size(), 4);
      check("seq5Cmd", logCmd[3], 4'd7);
      check("seq5Data", logData[3], 32'd1);

      // Freeze mid-command across three ticks: exactly one extra frame follows.
      clearLog();
      waitDrawEn(400);
      en = 1'b0;
      repeat (600) step();
      en = 1'b1;
      waitFrames(7, 300);
      repeat (80) step();
      check("coalesce", framesSeen, 7);
      check("seq67Len", logCmd.size(), 6);

      // Force refresh, with a ch1 update landing in the snapshot cycle.
      repeat (5) step();
      clearLog();
      fb = framesBuilt;
      forceRefresh = 1'b1; forceNext = 1'b1;
      step();
      forceRefresh = 1'b0;
      chData[63:32] = 32'hABCD; chValidIn = 2'b10;
      step();
      chValidIn = 2'b00;
      k = 0;
      while (framesBuilt == fb && k < 20) begin
         step();
         k++;
      end
      check("forceStart", framesBuilt, fb + 1);
      snapCh[1] = 32'hABCD;
      waitFrames(8, 200);
      check("seq8Len", logCmd.size(), 6);
      check("seq8Mode", logData[3], 32'd1);
      check("seq8Ch0", logData[4], 32'h1234);
      check("seq8Ch1Old", logData[5], 32'd0);

      clearLog();
      waitFrames(9, 400);
      check("seq9Len", logCmd.size(), 4);
      check("seq9Cmd", logCmd[3], 4'd9);
      check("seq9Data", logData[3], 32'hABCD);

      // Asynchronous reset during a command.
      waitDrawEn(400);
      step();
      rst_n = 1'b0;
      #1;
      check("asyncDrawEn", drawEn, 1'b0);
      check("asyncState", {initDone, busy, frameCnt}, '0);
      clearLog();
      step();
      step();
      rst_n = 1'b1;
      waitFrames(1, 300);
      check("seqRLen", logCmd.size(), 9);
      for (int i = 0; i < 9; i++) check("seqR", logCmd[i], fullSeq[i]);
      check("seqRMode", logData[6], 32'd1);
      check("cntR", frameCnt, 16'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule

// File: doc/draw_scheduler.md
# draw_scheduler

Parametrised scheduler that sequences drawing commands into the draw core through an en/done handshake. It replaces the fixed-sequence draw adapter between the acquisition logic and the draw core. Generalisations:
- N counter channels instead of two.
- Channel and mode slots are redrawn only when their value changed.
- Frames are paced by a refresh timer.
- A per-command timeout watchdog prevents a hung core from stalling the display.

## Interface
Parameters:
- NUM_CH, 2: counter channels drawn per frame (1..8).
- DATA_W, 32: channel data width.
- CH_CMD_BASE, 8: draw command for channel c is CH_CMD_BASE+c (4-bit, must not exceed 15).
- REFRESH_DIV, 1000000: clk cycles per refresh tick (≥2).
- TIMEOUT, 65535: max cycles o_draw_en may stay high per command (≥1).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- en  in  1  FSM advance enable; low freezes state and all outputs; timer keeps running.
- i_mode  in  2  active mode icon index.
- i_ch_data  in  NUM_CH*DATA_W  channel values, channel c at [c*DATA_W +: DATA_W].
- i_ch_valid  in  NUM_CH  per-channel update strobe.
- i_force_refresh  in  1  pulse: request a frame, all slots dirty.
- o_cmd  out  4  draw command to core.
- o_data  out  32  command argument, zero-extended.
- o_draw_en  out  1  command request to core.
- i_draw_done  in  1  core done.
- o_init_done  out  1  high after the init sequence completes; stays high.
- o_frame_done  out  1  1-cycle pulse at frame end.
- o_busy  out  1  high in any issue state.
- o_timeout_err  out  1  sticky; set on watchdog expiry.
- i_err_clr  in  1  clears o_timeout_err; a set in the same cycle wins.
- o_frame_cnt  out  16  completed frames, wraps at 65535→0.

## Operation
- Shadow registers: i_ch_valid[c] latches slice c into shadow[c]. Reset value 0.
- States:
  - RST_GAP: one cycle after reset.
  - INIT: issues cmd 0 (clear), then 1 (fixed image), then 4 (titles), all with data 0. Sets o_init_done, then goes to WAIT.
  - WAIT: frame request pending → SNAP.
  - SNAP: one cycle; copies shadow[] and i_mode into frame registers.
  - ISSUE: processes slots in order:
    - slot 0: cmd 2 (RTC)
    - slot 1: cmd 3 (wave)
    - slot 2: cmd 6 (histogram)
    - slot 3: cmd 7, data=mode
    - slots 4..4+NUM_CH-1: channel c
  - DONE: pulses o_frame_done, increments o_frame_cnt, returns to WAIT.
- Dirty rule:
  - Slots 0–2 are always drawn.
  - The mode slot and channel slots are drawn only if the frame value differs from the last successfully drawn value, or on the first frame, or after i_force_refresh.
  - A clean slot is skipped in 1 cycle with no handshake.
  - A successful draw updates that slot's last-drawn value.
- Frame request:
  - Refresh counter counts 0..REFRESH_DIV-1; a tick occurs on wrap.
  - A tick or i_force_refresh sets a pending flag, cleared in SNAP.
  - Multiple ticks during a frame coalesce into one pending request.
- Watchdog:
  - A counter runs while o_draw_en is high.
  - On reaching TIMEOUT: drop o_draw_en, set o_timeout_err, advance to the next slot.
  - A timed-out slot keeps its old last-drawn value, so it is retried next frame.
  - A timeout during INIT advances to the next init command.

## Timing
- Reset values: all outputs 0; state RST_GAP; pending flag 1, so the first frame runs right after init.
- Handshake:
  - o_cmd and o_data are set in the same cycle o_draw_en rises and are held stable while o_draw_en is high.
  - i_draw_done is honoured only while o_draw_en is high. On the sampled edge, o_draw_en is low the next cycle.
  - At least one cycle of o_draw_en low between consecutive commands (GAP cycle).
  - i_draw_done while o_draw_en is low is ignored.
- Latency: tick → SNAP 1 cycle (if WAIT); SNAP → first o_draw_en 1 cycle.
- Simultaneous i_ch_valid and SNAP: the snapshot takes the pre-update shadow value; the new value is drawn next frame.
- en low mid-handshake: o_draw_en held, done ignored until en returns; the watchdog is frozen.
- Async reset mid-command: o_draw_en drops immediately; restarts from RST_GAP with the full init sequence.

## Test plan
- Reset, core done 3 cycles after each en → cmd sequence 0,1,4,2,3,6,7,8,9; o_init_done after cmd 4; o_frame_cnt=1.
- NUM_CH=2, REFRESH_DIV=200, no data change → second frame issues only 2,3,6; ch0 set to 0x1234 → next frame adds cmd 8, data 0x00001234.
- Core never asserts done, TIMEOUT=16 → o_draw_en high exactly 16 cycles, o_timeout_err=1, next slot issued; i_err_clr clears it.
- 3 ticks during a long frame → exactly one following frame.
- i_ch_valid in the SNAP cycle → old value drawn this frame, new value next frame.
- i_force_refresh with no data change → mode and all channel slots redrawn.
